fb_pixel_writer: RTL

Framebuffer write stage sitting directly downstream of the GPU rasterizer output. It accepts the rasterizer's pixel stream (8-bit colour plus x/y), drops off-screen pixels, and converts byte-granular pixels into 32-bit framebuffer word writes with byte enables. Consecutive pixels landing in the same word are coalesced into one write. An optional clear pass fills the frame with a constant colour before drawing starts.

---
 rtl/fb_pixel_writer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: turns the rasterizer's byte-pixel stream into coalesced
// 32-bit framebuffer word writes, with an optional constant-colour clear pass
// that runs before drawing starts.
//
// Handshakes (pixel input and memory output): a transfer happens on the rising
// clk edge where valid && ready are both high. A producer holding valid keeps
// its payload stable until that edge. in_ready depends combinationally on
// mem_ready, so a pixel can be taken in the same cycle the output drains.
module fb_pixel_writer #(
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              clear_en,
  input  logic [7:0]        clear_color,
  input  logic [10:0]       width,
  input  logic [10:0]       height,
  input  logic [7:0]        in_color,
  input  logic [10:0]       in_x,
  input  logic [10:0]       in_y,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              frame_end,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       width_q, width_d;
  logic [10:0]       height_q, height_d;
  logic [7:0]        clr_color_q, clr_color_d;
  logic [20:0]       clr_total_q, clr_total_d;
  logic [20:0]       clr_cnt_q, clr_cnt_d;   // clear words issued so far
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [3:0]        pend_be_q, pend_be_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              flush_req_q, flush_req_d;
  logic              frame_end_q;             // frame_end delayed one cycle
  logic              done_q, done_d;

  logic [21:0]       frame_area;
  logic [22:0]       area_rnd;
  logic [20:0]       frame_words;
  logic [21:0]       byte_addr;
  logic [ADDR_W-1:0] pix_word;
  logic [1:0]        pix_lane;
  logic [3:0]        lane_onehot;
  logic              pix_in_range;
  logic              pix_accept;
  logic              out_free;
  logic              flush_edge;

  // Clear length: ceil(width*height/4) words, from the frame_start-time inputs.
  assign frame_area  = {11'd0, width} * {11'd0, height};
  assign area_rnd    = {1'b0, frame_area} + 23'd3;
  assign frame_words = area_rnd[22:2];

  // Pixel byte address is a full 22-bit product; the word address wraps.
  assign byte_addr    = ({11'd0, in_y} * {11'd0, width_q}) + {11'd0, in_x};
  assign pix_word     = BASE_ADDR + ADDR_W'(byte_addr[21:2]);
  assign pix_lane     = byte_addr[1:0];
  assign lane_onehot  = 4'b0001 << pix_lane;
  assign pix_in_range = (in_x < width_q) && (in_y < height_q);

  assign out_free   = !mem_valid_q || mem_ready;
  assign in_ready   = (state_q == DRAW) && !flush_req_q && out_free;
  assign pix_accept = in_valid && in_ready;
  assign flush_edge = frame_end && !frame_end_q;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_valid = mem_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Next-state logic: frame sequencing, clear issue, pixel coalescing, flush.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    clr_color_d  = clr_color_q;
    clr_total_d  = clr_total_q;
    clr_cnt_d    = clr_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_be_d    = pend_be_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    flush_req_d  = flush_req_q;
    done_d       = 1'b0;

    // A completed handshake empties the output register unless refilled below.
    if (mem_valid_q && mem_ready) mem_valid_d = 1'b0;

    // Flush edges during CLEAR are held until DRAW is reached.
    if (flush_edge && (state_q == CLEAR || state_q == DRAW)) flush_req_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          width_d     = width;
          height_d    = height;
          clr_color_d = clear_color;
          clr_total_d = frame_words;
          clr_cnt_d   = 21'd1;
          if (clear_en && frame_words != '0) begin
            state_d     = CLEAR;
            mem_valid_d = 1'b1;
            mem_addr_d  = BASE_ADDR;
            mem_wdata_d = {4{clear_color}};
            mem_be_d    = 4'hF;
          end else begin
            state_d = DRAW;
          end
        end
      end
      CLEAR: begin
        if (mem_valid_q && mem_ready) begin
          if (clr_cnt_q == clr_total_q) begin
            state_d = DRAW;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = BASE_ADDR + ADDR_W'(clr_cnt_q);
            mem_wdata_d = {4{clr_color_q}};
            mem_be_d    = 4'hF;
            clr_cnt_d   = clr_cnt_q + 21'd1;
          end
        end
      end
      DRAW: begin
        if (flush_req_q) begin
          state_d = FLUSH;
        end else if (pix_accept && pix_in_range) begin
          if (pend_valid_q && pend_addr_q == pix_word) begin
            pend_be_d = pend_be_q | lane_onehot;
            pend_data_d[{pix_lane, 3'b000} +: 8] = in_color;
          end else begin
            // in_ready already guarantees the output register is free here.
            if (pend_valid_q) begin
              mem_valid_d = 1'b1;
              mem_addr_d  = pend_addr_q;
              mem_wdata_d = pend_data_q;
              mem_be_d    = pend_be_q;
            end
            pend_valid_d = 1'b1;
            pend_addr_d  = pix_word;
            pend_be_d    = lane_onehot;
            pend_data_d  = '0;
            pend_data_d[{pix_lane, 3'b000} +: 8] = in_color;
          end
        end
      end
      FLUSH: begin
        if (pend_valid_q) begin
          if (out_free) begin
            mem_valid_d  = 1'b1;
            mem_addr_d   = pend_addr_q;
            mem_wdata_d  = pend_data_q;
            mem_be_d     = pend_be_q;
            pend_valid_d = 1'b0;
          end
        end else if (out_free) begin
          done_d      = 1'b1;
          flush_req_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any pending or outstanding write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      clr_color_q  <= '0;
      clr_total_q  <= '0;
      clr_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_be_q    <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      flush_req_q  <= 1'b0;
      frame_end_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      clr_color_q  <= clr_color_d;
      clr_total_q  <= clr_total_d;
      clr_cnt_q    <= clr_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_be_q    <= pend_be_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      flush_req_q  <= flush_req_d;
      frame_end_q  <= frame_end;
      done_q       <= done_d;
    end
  end

endmodule
